sprite_pixel_serializer: RTL and testbench

//   Consumes bit-reordered sprite ROM bytes: bit7 = opaque flag, bits[6:0] = pixel

---
 rtl/sprite_pixel_serializer.sv | 139 +++++++++++++
 tb/tb_sprite_pixel_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_serializer.sv
// Sprite pixel serializer: turns {opaque, pix[PIX_W-1:0]} ROM words into one pixel per pix_en tick.
// Latency: pix_en -> pix_out/pix_valid 1 clk; accept -> first pixel available after 2 clk (hold, then load).
// Backpressure: 1-entry hold register; in_ready drops while it is full, during line_start and during reset.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_in_valid/i_in_data      upstream word, pix[0] is the leftmost pixel, MSB is the opaque flag
//   o_in_ready                hold register can take a word this cycle
//   i_pix_en, i_line_start    VGA pixel tick, start-of-sprite-row flush
//   o_pix_out, o_pix_opaque   current pixel and its opaque flag (registered)
//   o_pix_valid               1-cycle strobe following each pix_en while a row is active
//   o_underrun                sticky: a pix_en found no data after the row started
module sprite_pixel_serializer #(
  parameter int PIX_W = 7,
  parameter int SCALE = 2,
  parameter int CW    = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_in_valid,
  input  logic [PIX_W:0] i_in_data,
  output logic           o_in_ready,
  input  logic           i_pix_en,
  input  logic           i_line_start,
  output logic           o_pix_out,
  output logic           o_pix_opaque,
  output logic           o_pix_valid,
  output logic           o_underrun
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [PIX_W:0]   r_hold_data;
  logic             r_hold_full;
  logic [PIX_W-1:0] r_sh;
  logic             r_sh_opq;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_rep_cnt;
  logic             r_armed;
  logic             r_pix_out;
  logic             r_pix_opaque;
  logic             r_pix_valid;
  logic             r_underrun;

  logic             w_accept;
  logic             w_rep_last;
  logic             w_word_last;

  // Reset also blocks acceptance so nothing is captured while the block is held in reset.
  assign o_in_ready  = ~r_hold_full & ~i_line_start & ~i_rst;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_rep_last  = (r_rep_cnt == CW'(SCALE - 1));
  assign w_word_last = w_rep_last && (r_bit_cnt == CW'(PIX_W - 1));

  assign o_pix_out    = r_pix_out;
  assign o_pix_opaque = r_pix_opaque;
  assign o_pix_valid  = r_pix_valid;
  assign o_underrun   = r_underrun;

  // Payload needs no reset: it is only ever read while r_hold_full is set.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_hold_data <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_line_start) begin
      // line_start is a full flush, including the sticky underrun flag.
      r_state      <= S_IDLE;
      r_hold_full  <= 1'b0;
      r_sh         <= '0;
      r_sh_opq     <= 1'b0;
      r_bit_cnt    <= '0;
      r_rep_cnt    <= '0;
      r_armed      <= 1'b0;
      r_pix_out    <= 1'b0;
      r_pix_opaque <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      // Accept needs an empty hold and every load needs a full one, so the
      // clear below never collides with this set in the same cycle.
      if (w_accept) r_hold_full <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // A tick here is the no-data case, even in a load cycle; it only
          // counts as an underrun once the row has started (armed).
          if (i_pix_en) begin
            r_pix_valid  <= r_armed;
            r_pix_out    <= 1'b0;
            r_pix_opaque <= 1'b0;
            if (r_armed) r_underrun <= 1'b1;
          end
          if (r_hold_full) begin
            r_sh        <= r_hold_data[PIX_W-1:0];
            r_sh_opq    <= r_hold_data[PIX_W];
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_armed     <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (i_pix_en) begin
            r_pix_out    <= r_sh[0];
            r_pix_opaque <= r_sh_opq;
            r_pix_valid  <= 1'b1;
            if (w_rep_last) begin
              r_rep_cnt <= '0;
              r_sh      <= r_sh >> 1;
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end else begin
              r_rep_cnt <= r_rep_cnt + CW'(1);
            end
            // End of word: chain straight into the held word without a bubble tick.
            if (w_word_last) begin
              if (r_hold_full) begin
                r_sh        <= r_hold_data[PIX_W-1:0];
                r_sh_opq    <= r_hold_data[PIX_W];
                r_hold_full <= 1'b0;
                r_bit_cnt   <= '0;
                r_rep_cnt   <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pixel_serializer.sv
// Directed testbench for sprite_pixel_serializer (PIX_W=7, SCALE=2).
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
// Expected pixel streams are hand-computed constants.
module tb_sprite_pixel_serializer;

  localparam int PIX_W = 7;
  localparam int SCALE = 2;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [PIX_W:0] in_data;
  logic           in_ready;
  logic           pix_en;
  logic           line_start;
  logic           pix_out;
  logic           pix_opaque;
  logic           pix_valid;
  logic           underrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [13:0] exp2;
  logic [13:0] exp4;

  always #5 clk = ~clk;

  sprite_pixel_serializer #(.PIX_W(PIX_W), .SCALE(SCALE), .CW(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .i_pix_en     (pix_en),
    .i_line_start (line_start),
    .o_pix_out    (pix_out),
    .o_pix_opaque (pix_opaque),
    .o_pix_valid  (pix_valid),
    .o_underrun   (underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp2 = 14'h0033;  // 8'h85: pix 0000101 -> 1,1,0,0,1,1,0...
    exp4 = 14'h000F;  // 8'h03: pix 0000011 -> 1,1,1,1,0...

    // 1: reset with a word offered
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h85; pix_en = 1'b0; line_start = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_pix_out", pix_out, 1'b0);
    chk("rst_pix_opaque", pix_opaque, 1'b0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_nothing_held", in_ready, 1'b1);
    pix_en = 1'b1; step(); pix_en = 1'b0;
    chk("rst_tick_no_valid", pix_valid, 1'b0);

    // 2: word 8'h85, pix_en every 4 clk
    in_valid = 1'b1; in_data = 8'h85;
    #1;
    chk("t2_ready_before", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_ready_held", in_ready, 1'b0);
    step();
    chk("t2_ready_after_load", in_ready, 1'b1);
    for (int i = 0; i < 14; i++) begin
      pix_en = 1'b1; step(); pix_en = 1'b0;
      chk($sformatf("t2_pix_out[%0d]", i), pix_out, exp2[i]);
      chk($sformatf("t2_opaque[%0d]", i), pix_opaque, 1'b1);
      chk($sformatf("t2_valid[%0d]", i), pix_valid, 1'b1);
      step();
      chk($sformatf("t2_valid_gap[%0d]", i), pix_valid, 1'b0);
      step(); step();
    end
    line_start = 1'b1; step(); line_start = 1'b0;

    // 3: 8'h7F and 8'h00 queued, pix_en every clk
    in_valid = 1'b1; in_data = 8'h7F;
    step();                       // accept 7F
    in_data = 8'h00;
    step();                       // load 7F, hold busy so 00 not taken
    step();                       // accept 00
    in_valid = 1'b0;
    chk("t3_hold_full", in_ready, 1'b0);
    pix_en = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step();
      chk($sformatf("t3_pix_out[%0d]", i), pix_out, (i < 14) ? 1'b1 : 1'b0);
      chk($sformatf("t3_valid[%0d]", i), pix_valid, 1'b1);
      chk($sformatf("t3_opaque[%0d]", i), pix_opaque, 1'b0);
    end
    pix_en = 1'b0;
    chk("t3_underrun", underrun, 1'b0);

    // 4: single word then ticks past its end
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("t4_underrun_clr", underrun, 1'b0);
    in_valid = 1'b1; in_data = 8'h03;
    step();
    in_valid = 1'b0;
    step();
    pix_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("t4_pix_out[%0d]", i), pix_out, exp4[i]);
    end
    chk("t4_no_underrun_yet", underrun, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("t4_ur_valid[%0d]", i), pix_valid, 1'b1);
      chk($sformatf("t4_ur_pix[%0d]", i), pix_out, 1'b0);
      chk($sformatf("t4_ur_flag[%0d]", i), underrun, 1'b1);
    end
    pix_en = 1'b0;
    step(); step(); step();
    chk("t4_underrun_sticky", underrun, 1'b1);
    chk("t4_valid_idle", pix_valid, 1'b0);
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("t4_underrun_flushed", underrun, 1'b0);

    // 5: flush mid-word with a second word held
    in_valid = 1'b1; in_data = 8'hFF;
    step();                       // accept FF
    in_valid = 1'b0;
    step();                       // load FF
    in_valid = 1'b1; in_data = 8'hAA;
    step();                       // accept AA
    in_valid = 1'b0;
    chk("t5_hold_full", in_ready, 1'b0);
    pix_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_pix_out[%0d]", i), pix_out, 1'b1);
      chk($sformatf("t5_opaque[%0d]", i), pix_opaque, 1'b1);
    end
    line_start = 1'b1;
    #1;
    chk("t5_ready_flush", in_ready, 1'b0);
    step();
    line_start = 1'b0; pix_en = 1'b0;
    #1;
    chk("t5_ready_next", in_ready, 1'b1);
    chk("t5_valid_flush", pix_valid, 1'b0);
    chk("t5_opaque_flush", pix_opaque, 1'b0);
    pix_en = 1'b1; step(); pix_en = 1'b0;
    chk("t5_tick_valid", pix_valid, 1'b0);
    chk("t5_tick_pix", pix_out, 1'b0);
    step(); step();
    pix_en = 1'b1; step(); pix_en = 1'b0;
    chk("t5_discarded", pix_valid, 1'b0);
    chk("t5_underrun", underrun, 1'b0);

    // 6: line_start and in_valid together
    line_start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    chk("t6_ready_ls", in_ready, 1'b0);
    step();
    line_start = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6_hold_empty", in_ready, 1'b1);
    step(); step();
    pix_en = 1'b1; step(); pix_en = 1'b0;
    chk("t6_no_word", pix_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
